// File: rtl/encoder_rr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// encoder_rr_pkg : shared FSM state type and request codes for encoder_rr
// Revision 1.0
// ---------------------------------------------------------------------------
package encoder_rr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Same bit mapping the 2-to-4 decoder consumes, a = MSB.
  localparam logic [1:0] CODE_D0 = 2'b00;
  localparam logic [1:0] CODE_D1 = 2'b01;
  localparam logic [1:0] CODE_D2 = 2'b10;
  localparam logic [1:0] CODE_D3 = 2'b11;

endpackage : encoder_rr_pkg
`default_nettype wire

// File: rtl/encoder_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin pick of one of four requests
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] code_o,
  output logic       any_o,
  output logic       multi_o
);

  logic [3:0] w_rot;
  logic [1:0] w_idx;

  // Rotate so that the request at ptr lands in bit 0, pick the lowest set
  // bit, then add ptr back to recover the absolute code.
  always_comb begin
    case (ptr_i)
      2'd0:    w_rot = req_i;
      2'd1:    w_rot = {req_i[0],   req_i[3:1]};
      2'd2:    w_rot = {req_i[1:0], req_i[3:2]};
      default: w_rot = {req_i[2:0], req_i[3]};
    endcase
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_idx = 2'(i);
    end
    code_o  = w_idx + ptr_i;
    any_o   = |req_i;
    multi_o = ($countones(req_i) > 1);
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/encoder_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// encoder_rr : registered 4-to-2 round-robin encoder with valid/ack handshake
// Revision 1.0
// ---------------------------------------------------------------------------
module encoder_rr
  import encoder_rr_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic e,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic ack,
  output logic a,
  output logic b,
  output logic v,
  output logic multi
);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] code_q, code_d;
  logic       v_q, v_d;
  logic       multi_q, multi_d;

  logic [3:0] w_req;
  logic [1:0] w_code;
  logic       w_any;
  logic       w_multi;

  assign w_req = {d3, d2, d1, d0};

  rr_pick u_pick (
    .req_i   (w_req),
    .ptr_i   (ptr_q),
    .code_o  (w_code),
    .any_o   (w_any),
    .multi_o (w_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      code_q  <= CODE_D0;
      v_q     <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      v_q     <= v_d;
      multi_q <= multi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (e && w_any) state_d = HOLD;
      HOLD:    if (ack)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs hold by default; they only move on capture or on ack.
  always_comb begin
    ptr_d   = ptr_q;
    code_d  = code_q;
    v_d     = v_q;
    multi_d = multi_q;
    if (state_q == IDLE) begin
      if (e && w_any) begin
        code_d  = w_code;
        v_d     = 1'b1;
        multi_d = w_multi;
      end
    end else if (ack) begin
      v_d = 1'b0;
      if (RR_EN != 0) ptr_d = code_q + 2'd1;
    end
  end

  assign a     = code_q[1];
  assign b     = code_q[0];
  assign v     = v_q;
  assign multi = multi_q;

endmodule : encoder_rr
`default_nettype wire

// File: tb/tb_encoder_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_encoder_rr : directed vector bench for encoder_rr (rotating and fixed)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_encoder_rr;
  import encoder_rr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [3:0] d;
  logic       ack;
  logic       a_r, b_r, v_r, m_r;
  logic       a_f, b_f, v_f, m_f;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       e;
    logic [3:0] d;
    logic       ack;
    logic       v;
    logic [1:0] code;
    logic       multi;
  } vec_t;

  vec_t tbl[$];

  encoder_rr #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .e(e),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .ack(ack), .a(a_r), .b(b_r), .v(v_r), .multi(m_r)
  );

  encoder_rr #(.RR_EN(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .e(e),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .ack(ack), .a(a_f), .b(b_f), .v(v_f), .multi(m_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {v,a,b,multi}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ie, input logic [3:0] id, input logic iack,
                     input logic ev, input logic [1:0] ec, input logic em);
    vec_t t;
    t.e = ie; t.d = id; t.ack = iack; t.v = ev; t.code = ec; t.multi = em;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    e = 1'b0; d = 4'b0000; ack = 1'b0;
    step();
    step();
    chk("reset_rr", {v_r, a_r, b_r, m_r}, 4'b0000);
    chk("reset_fx", {v_f, a_f, b_f, m_f}, 4'b0000);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Idle with enable, then d2 gated by e, held grant, ack.
    for (int i = 0; i < 5; i++) add(1, 4'b0000, 0, 0, CODE_D0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 0, 0, CODE_D0, 0);
    add(1, 4'b0100, 0, 1, CODE_D2, 0);
    add(1, 4'b0100, 0, 1, CODE_D2, 0);
    add(1, 4'b0100, 0, 1, CODE_D2, 0);
    add(1, 4'b0100, 1, 0, CODE_D2, 0);
    add(1, 4'b0000, 0, 0, CODE_D2, 0);
    // Grant d3 (ptr=3), then change inputs while held; ack wraps ptr to 0.
    add(1, 4'b1000, 0, 1, CODE_D3, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0001, 0, 1, CODE_D3, 0);
    add(0, 4'b0001, 1, 0, CODE_D3, 0);
    add(1, 4'b1111, 0, 1, CODE_D0, 1);
    add(1, 4'b1111, 1, 0, CODE_D0, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i].e; d = tbl[i].d; ack = tbl[i].ack;
      step();
      chk($sformatf("vec%0d", i), {v_r, a_r, b_r, m_r},
          {tbl[i].v, tbl[i].code, tbl[i].multi});
    end

    // Rotation (RR_EN=1) and fixed priority (RR_EN=0) under identical stimulus.
    do_reset();
    e = 1'b1; d = 4'b1111; ack = 1'b1;
    begin
      logic [1:0] exp_rr [5];
      exp_rr[0] = CODE_D0; exp_rr[1] = CODE_D1; exp_rr[2] = CODE_D2;
      exp_rr[3] = CODE_D3; exp_rr[4] = CODE_D0;
      for (int i = 0; i < 9; i++) begin
        step();
        if (i % 2 == 0) begin
          chk($sformatf("rot%0d", i), {v_r, a_r, b_r, m_r}, {1'b1, exp_rr[i/2], 1'b1});
          chk($sformatf("fix%0d", i), {v_f, a_f, b_f, m_f}, {1'b1, CODE_D0, 1'b1});
        end else begin
          chk($sformatf("rot%0d", i), {v_r, a_r, b_r, m_r}, {1'b0, exp_rr[i/2], 1'b1});
          chk($sformatf("fix%0d", i), {v_f, a_f, b_f, m_f}, {1'b0, CODE_D0, 1'b1});
        end
      end
    end
    d = 4'b1110;
    step();
    chk("fix_drop_ack", {v_f, a_f, b_f, m_f}, {1'b0, CODE_D0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fix_d1_%0d", i), {v_f, a_f, b_f, m_f},
          {(i % 2 == 0), CODE_D1, 1'b1});
    end

    // Reset mid-HOLD: move ptr to 1, hold code 01, then async reset.
    do_reset();
    e = 1'b1; d = 4'b0001; ack = 1'b0;
    step();
    ack = 1'b1; d = 4'b0000;
    step();
    ack = 1'b0; d = 4'b0110;
    step();
    chk("hold01", {v_r, a_r, b_r, m_r}, {1'b1, CODE_D1, 1'b1});
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {v_r, a_r, b_r, m_r}, 4'b0000);
    #1 rst_n = 1'b1;
    d = 4'b1111;
    step();
    chk("post_rst_grant", {v_r, a_r, b_r, m_r}, {1'b1, CODE_D0, 1'b1});
    step();
    chk("post_rst_hold", {v_r, a_r, b_r, m_r}, {1'b1, CODE_D0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_encoder_rr
`default_nettype wire
